// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: FSM encoding, default frame
// geometry and a counter-width helper used by the top and the bit timer.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DATA_BITS_DEF       = 8;
  localparam int SAMPLES_PER_BIT_DEF = 16;
  localparam int FRAME_BITS_DEF      = DATA_BITS_DEF + 2;
  localparam int FRAME_CYCLES_DEF    = FRAME_BITS_DEF * SAMPLES_PER_BIT_DEF;

  // Bits on the line per frame: start + payload + stop.
  function automatic int frame_bits(input int data_bits);
    return data_bits + 2;
  endfunction

  // Width needed to hold 0..terminal, never less than one bit.
  function automatic int cnt_width(input int terminal);
    return (terminal > 0) ? $clog2(terminal + 1) : 1;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit timing for one frame: sample counter (bsc) and bit index counter (bic), held at 0 while run is low.
// bit_tick is combinational and marks the last sample of the current bit; no backpressure.
module tx_bit_timer
  import serial_pkg::*;
#(
  parameter int  DATA_BITS       = DATA_BITS_DEF,
  parameter int  SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
  localparam int BSC_W           = cnt_width(SAMPLES_PER_BIT - 1),
  localparam int BIC_W           = cnt_width(DATA_BITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  output logic [BSC_W-1:0] bsc,
  output logic [BIC_W-1:0] bic,
  output logic             bit_tick
);

  localparam logic [BSC_W-1:0] BSC_LAST = BSC_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIC_W-1:0] BIC_LAST = BIC_W'(frame_bits(DATA_BITS) - 1);

  assign bit_tick = run && (bsc == BSC_LAST);

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      bsc <= '0;
      bic <= '0;
    end else if (bit_tick) begin
      bsc <= '0;
      // The stop bit's wrap returns bic to 0 rather than overshooting its terminal value.
      bic <= (bic == BIC_LAST) ? '0 : bic + 1'b1;
    end else begin
      bsc <= bsc + 1'b1;
    end
  end

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in serial-out framer: start bit, DATA_BITS payload LSB first, stop bit; tx_out registered, one cycle after accept.
// load is taken only in IDLE; requests while busy are dropped, never queued.
module piso_transmitter
  import serial_pkg::*;
#(
  parameter int   DATA_BITS       = DATA_BITS_DEF,
  parameter int   SAMPLES_PER_BIT = SAMPLES_PER_BIT_DEF,
  parameter logic IDLE_LEVEL      = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  output logic                 busy,
  output logic                 tx_out,
  output logic                 tx_done
);

  localparam int BSC_W = cnt_width(SAMPLES_PER_BIT - 1);
  localparam int BIC_W = cnt_width(DATA_BITS + 1);
  localparam logic [BSC_W-1:0] BSC_LAST      = BSC_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIC_W-1:0] BIC_LAST_DATA = BIC_W'(DATA_BITS);

  tx_state_t            state, state_d;
  logic [DATA_BITS-1:0] shreg, shreg_d;
  logic                 tx_out_d;
  logic [BSC_W-1:0]     bsc;
  logic [BIC_W-1:0]     bic;
  logic                 bit_tick;

  tx_bit_timer #(
    .DATA_BITS       (DATA_BITS),
    .SAMPLES_PER_BIT (SAMPLES_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (state != IDLE),
    .bsc      (bsc),
    .bic      (bic),
    .bit_tick (bit_tick)
  );

  assign busy    = (state != IDLE);
  assign tx_done = (state == STOP) && (bsc == BSC_LAST);

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    case (state)
      IDLE: begin
        if (load) begin
          state_d = START;
          shreg_d = data_in;
        end
      end
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick) begin
          shreg_d = shreg >> 1;
          if (bic == BIC_LAST_DATA) state_d = STOP;
        end
      end
      STOP: if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The line level follows the next state so tx_out stays cycle-aligned with busy.
    case (state_d)
      START:   tx_out_d = ~IDLE_LEVEL;
      DATA:    tx_out_d = shreg_d[0];
      default: tx_out_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      tx_out <= IDLE_LEVEL;
    end else begin
      state  <= state_d;
      shreg  <= shreg_d;
      tx_out <= tx_out_d;
    end
  end

endmodule

// File: tb/tb_piso_transmitter.sv
// Directed bench: reset/abort/back-to-back sequences by hand, then a table of frames
// with hand-computed line patterns checked cycle by cycle on both idle polarities.
module tb_piso_transmitter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load0 = 1'b0, load1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       busy0, tx0, done0, busy1, tx1, done1;

  int checks = 0;
  int errors = 0;

  piso_transmitter #(.DATA_BITS(8), .SAMPLES_PER_BIT(16), .IDLE_LEVEL(1'b0)) dut0 (
    .clk(clk), .reset(reset), .data_in(data0), .load(load0),
    .busy(busy0), .tx_out(tx0), .tx_done(done0)
  );

  piso_transmitter #(.DATA_BITS(8), .SAMPLES_PER_BIT(16), .IDLE_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data1), .load(load1),
    .busy(busy1), .tx_out(tx1), .tx_done(done1)
  );

  always #5 clk = ~clk;

  // line[i] is the level of serial bit i in time order: start, d0..d7, stop.
  typedef struct {
    logic [7:0] data;
    logic       il;
    int         inject_at;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int v);
    vec_t       t;
    logic [2:0] o, e;
    t = vecs[v];
    @(negedge clk);
    if (t.il) begin load1 = 1'b1; data1 = t.data; end
    else      begin load0 = 1'b1; data0 = t.data; end
    @(posedge clk);
    for (int k = 1; k <= 165; k++) begin
      @(negedge clk);
      o = t.il ? {tx1, busy1, done1} : {tx0, busy0, done0};
      if (k <= 160) e = {t.line[(k - 1) / 16], 1'b1, (k == 160)};
      else          e = {t.il, 1'b0, 1'b0};
      check($sformatf("vec%0d cycle%0d {tx,busy,done}", v, k), {29'd0, o}, {29'd0, e});
      load0 = 1'b0;
      load1 = 1'b0;
      if (t.inject_at != 0 && k >= t.inject_at && k < t.inject_at + 4) begin
        if (t.il) begin load1 = 1'b1; data1 = 8'hFF; end
        else      begin load0 = 1'b1; data0 = 8'hFF; end
      end
    end
  endtask

  initial begin
    logic done_seen;
    int   idle_wait;

    vecs[0] = '{data: 8'hA5, il: 1'b0, inject_at: 0,   line: 10'b0101001011};
    vecs[1] = '{data: 8'hA5, il: 1'b0, inject_at: 40,  line: 10'b0101001011};
    vecs[2] = '{data: 8'h00, il: 1'b0, inject_at: 0,   line: 10'b0000000001};
    vecs[3] = '{data: 8'h81, il: 1'b0, inject_at: 100, line: 10'b0100000011};
    vecs[4] = '{data: 8'h3C, il: 1'b1, inject_at: 0,   line: 10'b1001111000};
    vecs[5] = '{data: 8'hFF, il: 1'b1, inject_at: 70,  line: 10'b1111111110};

    // Reset state on both polarities.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset tx0", {31'd0, tx0}, 32'd0);
    check("reset busy0", {31'd0, busy0}, 32'd0);
    check("reset done0", {31'd0, done0}, 32'd0);
    check("reset tx1", {31'd0, tx1}, 32'd1);
    check("reset busy1", {31'd0, busy1}, 32'd0);

    // Reset and load on the same edge: reset wins.
    load0 = 1'b1;
    data0 = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    check("reset+load busy0", {31'd0, busy0}, 32'd0);
    check("reset+load tx0", {31'd0, tx0}, 32'd0);

    // Load held across reset release is accepted on the first free edge.
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post-reset accept busy0", {31'd0, busy0}, 32'd1);
    check("post-reset accept tx0", {31'd0, tx0}, 32'd1);
    load0 = 1'b0;

    // Abort that frame at cycle 70.
    done_seen = done0;
    for (int k = 2; k <= 70; k++) begin
      @(negedge clk);
      done_seen = done_seen | done0;
      if (k == 17) check("abort frame d0 of A5", {31'd0, tx0}, 32'd1);
      if (k == 33) check("abort frame d1 of A5", {31'd0, tx0}, 32'd0);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("no tx_done before abort", {31'd0, done_seen}, 32'd0);
    check("abort tx0", {31'd0, tx0}, 32'd0);
    check("abort busy0", {31'd0, busy0}, 32'd0);
    check("abort done0", {31'd0, done0}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("abort stays idle", {31'd0, busy0}, 32'd0);

    // Load held high: 00 frame, one IDLE cycle, FF frame.
    load0 = 1'b1;
    data0 = 8'h00;
    @(posedge clk);
    for (int k = 1; k <= 323; k++) begin
      @(negedge clk);
      case (k)
        1:   check("b2b f1 start", {30'd0, tx0, busy0}, 32'b11);
        16:  check("b2b f1 start end", {31'd0, tx0}, 32'd1);
        17:  check("b2b f1 d0", {31'd0, tx0}, 32'd0);
        159: check("b2b f1 no early done", {31'd0, done0}, 32'd0);
        160: check("b2b f1 done", {29'd0, tx0, busy0, done0}, 32'b011);
        161: check("b2b idle gap", {29'd0, tx0, busy0, done0}, 32'b000);
        162: check("b2b f2 start", {30'd0, tx0, busy0}, 32'b11);
        178: check("b2b f2 d0", {31'd0, tx0}, 32'd1);
        321: check("b2b f2 done", {29'd0, tx0, busy0, done0}, 32'b011);
        322: check("b2b after f2", {30'd0, busy0, done0}, 32'b00);
        323: check("b2b no third frame", {31'd0, busy0}, 32'd0);
        default: ;
      endcase
      if (k == 1)   data0 = 8'hFF;
      if (k == 163) load0 = 1'b0;
    end

    // Table of full frames.
    for (int v = 0; v < 6; v++) begin
      idle_wait = 0;
      while ((busy0 || busy1) && idle_wait < serial_pkg::FRAME_CYCLES_DEF * 2) begin
        @(negedge clk);
        idle_wait++;
      end
      if (busy0 || busy1) check($sformatf("vec%0d wait idle", v), 32'd1, 32'd0);
      run_vec(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
